// File: rtl/alu_pkg.sv
// Shared types for the shared-ALU controller: operation encoding, per-port
// request state and the datapath width.
package alu_pkg;

   localparam int ALU_W = 32;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5,
      ALU_SLL = 3'd6,
      ALU_SRL = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      FREE     = 2'd0,
      INFLIGHT = 2'd1,
      DONE     = 2'd2
   } port_state_e;

endpackage

// File: rtl/alu.sv
// Core 32-bit ALU: purely combinational, wraps modulo 2^32, shifts use b[4:0].
module alu
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a_i,
   input  logic [ALU_W-1:0] b_i,
   input  alu_op_e          op_i,
   output logic [ALU_W-1:0] result_o,
   output logic             zero_o
);

   logic [ALU_W-1:0] diff;

   // One subtractor serves both SUB and SLT; SLT takes the raw sign of the
   // wrapped difference without any overflow correction.
   always_comb begin
      diff     = a_i - b_i;
      result_o = '0;
      case (op_i)
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: result_o = diff;
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_XOR: result_o = a_i ^ b_i;
         ALU_SLT: result_o = {{(ALU_W-1){1'b0}}, diff[ALU_W-1]};
         ALU_SLL: result_o = a_i << b_i[4:0];
         ALU_SRL: result_o = a_i >> b_i[4:0];
         default: result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The caller owns the last-grant pointer;
// the search starts one past it and wraps modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_vld
);

   // Walk the ports in priority order and keep only the first eligible one,
   // so the grant vector is one-hot or zero.
   always_comb begin
      logic [IDX_W-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDX_W'((int'(last_grant) + 1 + k) % NUM_REQ);
         if (!grant_vld && eligible[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            grant_vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shared-ALU controller: serialises requests from NUM_REQ requesters onto one
// ALU. Only one operation is ever in flight because the operand register is
// shared; each port keeps its own response register until it is consumed.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ-1:0][ALU_W-1:0]   req_a,
   input  logic [NUM_REQ-1:0][ALU_W-1:0]   req_b,
   input  logic [NUM_REQ-1:0][2:0]         req_op,
   output logic [NUM_REQ-1:0]              resp_valid,
   input  logic [NUM_REQ-1:0]              resp_ready,
   output logic [NUM_REQ-1:0][ALU_W-1:0]   resp_result,
   output logic [NUM_REQ-1:0]              resp_zero,
   output logic                            busy
);

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grantIdx;
   logic               grantVld;
   logic [NUM_REQ-1:0] inflightVec;
   logic [NUM_REQ-1:0] busyVec;
   logic               anyInflight;

   logic [ALU_W-1:0]   aluA_q, aluA_d;
   logic [ALU_W-1:0]   aluB_q, aluB_d;
   alu_op_e            aluOp_q, aluOp_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   lastGrant_q, lastGrant_d;

   logic [ALU_W-1:0]   aluResult;
   logic               aluZero;

   assign anyInflight = |inflightVec;
   assign req_ready   = grant;
   assign busy        = |busyVec;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .eligible   (eligible),
      .last_grant (lastGrant_q),
      .grant      (grant),
      .grant_idx  (grantIdx),
      .grant_vld  (grantVld)
   );

   alu u_alu (
      .a_i      (aluA_q),
      .b_i      (aluB_q),
      .op_i     (aluOp_q),
      .result_o (aluResult),
      .zero_o   (aluZero)
   );

   // Shared operand, owner and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aluA_q      <= '0;
         aluB_q      <= '0;
         aluOp_q     <= ALU_ADD;
         owner_q     <= '0;
         lastGrant_q <= IDX_W'(NUM_REQ-1);
      end else begin
         aluA_q      <= aluA_d;
         aluB_q      <= aluB_d;
         aluOp_q     <= aluOp_d;
         owner_q     <= owner_d;
         lastGrant_q <= lastGrant_d;
      end
   end

   // Operands of the winning port are sampled only on an accepted transfer,
   // which is also the only moment the priority pointer moves.
   always_comb begin
      aluA_d      = aluA_q;
      aluB_d      = aluB_q;
      aluOp_d     = aluOp_q;
      owner_d     = owner_q;
      lastGrant_d = lastGrant_q;
      if (grantVld) begin
         aluA_d      = req_a[grantIdx];
         aluB_d      = req_b[grantIdx];
         aluOp_d     = alu_op_e'(req_op[grantIdx]);
         owner_d     = grantIdx;
         lastGrant_d = grantIdx;
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
      port_state_e      state_q, state_d;
      logic [ALU_W-1:0] result_q, result_d;
      logic             zero_q, zero_d;
      logic             capture;
      logic             isDone;
      logic             isInflight;
      logic             isBusy;

      assign capture = (state_q == INFLIGHT) && (owner_q == IDX_W'(i));

      // Per-port state and response registers.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q  <= FREE;
            result_q <= '0;
            zero_q   <= 1'b0;
         end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
         end
      end

      // FREE -> INFLIGHT on accept, INFLIGHT -> DONE with response capture on
      // the very next edge, DONE -> FREE once the requester takes it.
      always_comb begin
         state_d  = state_q;
         result_d = result_q;
         zero_d   = zero_q;
         case (state_q)
            FREE: begin
               if (grant[i]) state_d = INFLIGHT;
            end
            INFLIGHT: begin
               state_d = DONE;
               if (capture) begin
                  result_d = aluResult;
                  zero_d   = aluZero;
               end
            end
            DONE: begin
               if (resp_ready[i]) state_d = FREE;
            end
            default: state_d = FREE;
         endcase
      end

      // Decode the port state into its handshake and status flags.
      always_comb begin
         isDone     = (state_q == DONE);
         isInflight = (state_q == INFLIGHT);
         isBusy     = (state_q != FREE);
      end

      assign eligible[i]    = rst_n && req_valid[i] && (state_q == FREE) && !anyInflight;
      assign inflightVec[i] = isInflight;
      assign busyVec[i]     = isBusy;
      assign resp_valid[i]  = isDone;
      assign resp_result[i] = result_q;
      assign resp_zero[i]   = zero_q;
   end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Shared-ALU controller: accepts ALU operation requests from `NUM_REQ` independent requesters (core pipeline, coprocessor, debug unit) and serialises them onto a single instance of the core `alu`. It arbitrates round-robin, registers operands, captures the result and zero flag into a per-requester response register, and holds each response until its requester takes it. It sits between the requesters and the shared `alu`, which it instantiates.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; legal range 2..4.
- `IDX_W`, `$clog2(NUM_REQ)`: width of the grant index; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  `[NUM_REQ]`  requester i presents an operation.
- `req_ready`  out  `[NUM_REQ]`  operation accepted this cycle when `req_valid[i] & req_ready[i]`.
- `req_a`, `req_b`  in  `[NUM_REQ][32]`  operands.
- `req_op`  in  `[NUM_REQ][3]`  operation, `alu_op_e` encoding.
- `resp_valid`  out  `[NUM_REQ]`  response held for requester i.
- `resp_ready`  in  `[NUM_REQ]`  requester i consumes the response.
- `resp_result`  out  `[NUM_REQ][32]`  registered ALU result.
- `resp_zero`  out  `[NUM_REQ]`  registered `result == 0`.
- `busy`  out  1  at least one requester is not FREE.

## Operation
- Per-requester state: FREE -> INFLIGHT -> DONE -> FREE.
- FREE -> INFLIGHT: transfer accepted on port i.
- INFLIGHT -> DONE: the following edge. `alu` evaluates the registered operands; `resp_result[i]` and `resp_zero[i]` are captured.
- DONE -> FREE: edge with `resp_valid[i] & resp_ready[i]`.
- Eligible port: `req_valid[i]` and state FREE, and no other port in INFLIGHT. The single operand register is shared, so at most one op is in flight.
- Arbitration: among eligible ports, grant the first at or after `(last_grant + 1) mod NUM_REQ`. `req_ready` is one-hot or zero and asserts only on the granted port. `req_ready[i]` depends combinationally on `req_valid` of all ports.
- `last_grant` updates only on an accepted transfer. Reset value is `NUM_REQ-1`, so port 0 has first priority.
- ALU ops:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4.
  - SLT=5: result = bit 31 of `a-b` zero-extended. No overflow correction.
  - SLL=6, SRL=7: shift amount `b[4:0]`.
- All arithmetic is 32-bit modulo 2^32; carry is discarded.
- Response registers do not change while DONE.
- `resp_valid[i]` = (state == DONE).

## Timing
- Reset values: `req_ready` 0, `resp_valid` 0, `resp_result` 0, `resp_zero` 0, `busy` 0. All ports FREE.
- Reset asserted mid-operation drops in-flight ops and held responses with no partial update. The first grant after reset release is possible in the first cycle `rst_n` is high.
- Latency: accept at edge T, `resp_valid` high after edge T+1. If `resp_ready` is held high, the response is consumed at edge T+2.
- Throughput: one accept every 2 cycles across all ports. A given port can issue at most one op per 3 cycles, because it is not eligible during DONE or in the cycle its response is consumed.
- A port may accept in the cycle after another port's INFLIGHT->DONE edge, even while that port is still DONE.
- `resp_ready` while `resp_valid` is low: ignored.
- `req_valid` dropping before acceptance is legal. Its operands are never sampled.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` (3-bit enum, values above).
  - `port_state_e` (FREE, INFLIGHT, DONE).
  - `ALU_W = 32`.
- Sub-module `rr_arbiter #(NUM_REQ)`: inputs `eligible`, `last_grant`; outputs one-hot `grant`, `grant_idx`, `grant_vld`. Purely combinational; the pointer register lives in `alu_share_ctrl`.
- `alu_share_ctrl` holds the operand/op/owner registers, per-port state and response registers, and instantiates `alu`.

## Test plan
- Reset, then port 0 SUB a=5 b=7, `resp_ready` high -> accept at edge T. `resp_valid[0]` high after T+1 with result 0xFFFF_FFFE, zero 0. Port returns to FREE after T+2.
- Port 0 and port 1 both valid from reset with XOR a=b=0x1234_5678 -> port 0 granted first, then port 1 two cycles later. Port 1 gets result 0, zero 1. Grants alternate 0,1,0,1 while both keep requesting.
- Port 1 holds `resp_ready` low for 10 cycles after SLL a=1 b=0x25 -> `resp_result[1]` stays 0x20 throughout. Port 0 ops complete meanwhile. Port 1 gets no `req_ready` until its response is consumed.
- SLT a=0x8000_0000 b=1 -> result 0 (sign of the wrapped difference). SRL a=0x8000_0000 b=31 -> result 1.
- Assert `rst_n` low during INFLIGHT on port 0 -> all outputs 0 immediately. After release, no stale `resp_valid`. A new request is accepted in the first cycle out of reset.
- `NUM_REQ=4` with all ports valid continuously -> grant order 0,1,2,3,0. No port is starved; every accept is 2 cycles apart.
